// File: rtl/dpram_arb_pkg.sv
// Shared types and constants for the dual-port RAM port-A arbiter.
package dpram_arb_pkg;

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Tag riding alongside an in-flight RAM read.
  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_tag_t;

  // Deepest RAM read latency the tag pipe supports.
  localparam int unsigned RD_LATENCY_MAX = 8;

  // The requester that is not `id`.
  function automatic req_id_t other_id(input req_id_t id);
    return req_id_t'(~id);
  endfunction

endpackage

// File: rtl/dpram_rd_tag_pipe.sv
// Shift register of read tags; its depth equals the RAM read latency so the
// tag leaving the pipe lines up with the RAM read data it describes.
module dpram_rd_tag_pipe
  import dpram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH-1:0] stage_q;

  if (DEPTH == 1) begin : g_one
    // Single-stage pipe: one register, cleared on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= tag_in;
      end
    end
  end else begin : g_many
    // Multi-stage pipe: shift toward the top index, cleared on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[DEPTH-2:0], tag_in};
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dpram_porta_arbiter.sv
// Round-robin arbiter sharing one RAM port between two requesters: grant
// logic with a priority pointer, a registered command stage driving the RAM,
// a read-tag pipe matched to the RAM latency and a registered response demux.
module dpram_porta_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_din0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  // requester 1
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_din1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  // RAM port
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  // Out-of-range latencies are clamped into the supported 1..RD_LATENCY_MAX.
  localparam int unsigned PIPE_DEPTH =
    (RD_LATENCY < 1)              ? 1 :
    (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;

  req_id_t               prio_q;     // requester that wins when both request
  req_id_t               cmd_id_q;   // owner of the command in the RAM register
  logic                  gnt_any;
  req_id_t               win_id;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_din;
  rd_tag_t               tag_in;
  rd_tag_t               tag_out;

  // Grant: lone requester wins; on contention the pointer decides; none in reset.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (!rst) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = (prio_q == REQ0);
        o_gnt1 = (prio_q == REQ1);
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  // Winner mux feeding the command register.
  always_comb begin
    gnt_any  = o_gnt0 | o_gnt1;
    win_id   = o_gnt1 ? REQ1 : REQ0;
    win_we   = o_gnt1 ? i_we1   : i_we0;
    win_addr = o_gnt1 ? i_addr1 : i_addr0;
    win_din  = o_gnt1 ? i_din1  : i_din0;
  end

  // Priority pointer: after a grant the other requester gets precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= REQ0;
    end else if (gnt_any) begin
      prio_q <= other_id(win_id);
    end
  end

  // Command register: enable/write strobe every cycle, address/data only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ram_en   <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
      cmd_id_q   <= REQ0;
    end else begin
      o_ram_en <= gnt_any;
      o_ram_we <= gnt_any & win_we;
      if (gnt_any) begin
        o_ram_addr <= win_addr;
        o_ram_din  <= win_din;
        cmd_id_q   <= win_id;
      end
    end
  end

  // Tag the command currently on the RAM port; only reads carry a valid tag.
  always_comb begin
    tag_in     = '0;
    tag_in.vld = o_ram_en & ~o_ram_we;
    tag_in.id  = cmd_id_q;
  end

  dpram_rd_tag_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Response demux: route RAM data to the requester named by the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata0  <= '0;
      o_rdata1  <= '0;
    end else begin
      o_rvalid0 <= tag_out.vld && (tag_out.id == REQ0);
      o_rvalid1 <= tag_out.vld && (tag_out.id == REQ1);
      if (tag_out.vld && (tag_out.id == REQ0)) begin
        o_rdata0 <= i_ram_dout;
      end
      if (tag_out.vld && (tag_out.id == REQ1)) begin
        o_rdata1 <= i_ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_dpram_porta_arbiter.sv
// Bench for dpram_porta_arbiter: three instances (read latency 1, 3, 8) share
// one stimulus stream, each with its own RAM model. A reference arbiter and
// memory push expected read responses at grant time; a per-cycle monitor
// compares grants, RAM commands and responses against them.
module tb_dpram_porta_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned NI = 3;
  localparam int unsigned NT = 18;

  logic clk = 1'b0;
  logic rst;
  logic req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1;

  logic [NI-1:0]         gnt0_w, gnt1_w, rv0_w, rv1_w, en_w, we_w;
  logic [NI-1:0][DW-1:0] rd0_w, rd1_w, din_w, dout_w;
  logic [NI-1:0][AW-1:0] addr_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 3 : 8;
    logic [DW-1:0] mem  [16];
    logic [DW-1:0] pipe [LAT];

    dpram_porta_arbiter #(
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (16),
      .RD_LATENCY (LAT)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_req0     (req0),
      .i_we0      (we0),
      .i_addr0    (addr0),
      .i_din0     (din0),
      .o_gnt0     (gnt0_w[g]),
      .o_rvalid0  (rv0_w[g]),
      .o_rdata0   (rd0_w[g]),
      .i_req1     (req1),
      .i_we1      (we1),
      .i_addr1    (addr1),
      .i_din1     (din1),
      .o_gnt1     (gnt1_w[g]),
      .o_rvalid1  (rv1_w[g]),
      .o_rdata1   (rd1_w[g]),
      .o_ram_en   (en_w[g]),
      .o_ram_we   (we_w[g]),
      .o_ram_addr (addr_w[g]),
      .o_ram_din  (din_w[g]),
      .i_ram_dout (dout_w[g])
    );

    initial for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17) ^ 8'h5A;

    // RAM port model: read data appears LAT cycles after the enable cycle.
    always @(posedge clk) begin
      if (en_w[g] && we_w[g]) mem[addr_w[g]] <= din_w[g];
      pipe[0] <= (en_w[g] && !we_w[g]) ? mem[addr_w[g]] : 8'hEE;
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign dout_w[g] = pipe[LAT-1];
  end

  typedef struct {
    logic r0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0; logic g1;
  } vec_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            base;
  } exp_t;

  exp_t          sb[$];
  int            hd[NI];
  int            lat[NI] = '{1, 3, 8};
  logic          prio;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] e_rd0[NI], e_rd1[NI];
  int            cyc = 0;
  vec_t          tbl[NT];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic w0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic r1, input logic w1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; din0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; din1 = v.d1;
  endtask

  task automatic idle(input int n);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string nm, input vec_t v);
    for (int k = 0; k < int'(NI); k++) begin
      chk({nm, "_gnt0"}, k, 32'(gnt0_w[k]), 32'(v.g0));
      chk({nm, "_gnt1"}, k, 32'(gnt1_w[k]), 32'(v.g1));
    end
  endtask

  // Per-cycle monitor: reference arbiter, command model and response scoreboard.
  always @(negedge clk) begin : mon
    logic          eg0, eg1, ev0, ev1, wid, wwe;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    exp_t          e;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        eg0 = (prio == 1'b0);
        eg1 = (prio == 1'b1);
      end else begin
        eg0 = req0;
        eg1 = req1;
      end
    end
    for (int k = 0; k < int'(NI); k++) begin
      chk("gnt0", k, 32'(gnt0_w[k]), 32'(eg0));
      chk("gnt1", k, 32'(gnt1_w[k]), 32'(eg1));
      chk("ram_en", k, 32'(en_w[k]), 32'(m_en));
      chk("ram_we", k, 32'(we_w[k]), 32'(m_we));
      chk("ram_addr", k, 32'(addr_w[k]), 32'(m_addr));
      chk("ram_din", k, 32'(din_w[k]), 32'(m_din));
      ev0 = 1'b0;
      ev1 = 1'b0;
      if (hd[k] < sb.size() && sb[hd[k]].base + lat[k] == cyc) begin
        e = sb[hd[k]];
        hd[k]++;
        if (e.id) begin ev1 = 1'b1; e_rd1[k] = e.data; end
        else      begin ev0 = 1'b1; e_rd0[k] = e.data; end
      end
      chk("rvalid0", k, 32'(rv0_w[k]), 32'(ev0));
      chk("rvalid1", k, 32'(rv1_w[k]), 32'(ev1));
      chk("rdata0", k, 32'(rd0_w[k]), 32'(e_rd0[k]));
      chk("rdata1", k, 32'(rd1_w[k]), 32'(e_rd1[k]));
    end
    if (rst) begin
      prio = 1'b0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
      for (int k = 0; k < int'(NI); k++) begin
        hd[k] = sb.size(); e_rd0[k] = '0; e_rd1[k] = '0;
      end
    end else begin
      m_en = eg0 | eg1;
      m_we = 1'b0;
      if (eg0 | eg1) begin
        wid = eg1;
        wwe = eg1 ? we1 : we0;
        wa  = eg1 ? addr1 : addr0;
        wd  = eg1 ? din1 : din0;
        m_we = wwe; m_addr = wa; m_din = wd;
        prio = ~wid;
        if (wwe) ref_mem[wa] = wd;
        else begin
          e.id = wid; e.data = ref_mem[wa]; e.base = cyc + 2;
          sb.push_back(e);
        end
      end
    end
    cyc++;
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 17) ^ 8'h5A;
    prio = 1'b0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
    for (int k = 0; k < int'(NI); k++) begin hd[k] = 0; e_rd0[k] = '0; e_rd1[k] = '0; end

    //          r0 w0 a0 d0     r1 w1 a1 d1     g0 g1
    tbl[0]  = mk(1, 1, 3, 8'hA5, 0, 0, 0, 8'h00, 1, 0);  // req0 write A5 @3
    tbl[1]  = mk(1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 0);  // req0 read @3
    tbl[2]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    tbl[3]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 1, 1, 2, 8'h3C, 0, 1);  // req1 write 3C @2
    tbl[5]  = mk(1, 1, 1, 8'hC3, 0, 0, 0, 8'h00, 1, 0);  // req0 write C3 @1
    tbl[6]  = mk(0, 0, 0, 8'h00, 1, 0, 2, 8'h00, 0, 1);  // req1 alone, pointer -> req0
    tbl[7]  = mk(1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 1, 0);  // contention: 0,1,0,1,0,1
    tbl[8]  = mk(1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 0, 1);
    tbl[9]  = mk(1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 1, 0);
    tbl[10] = mk(1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 0, 1);
    tbl[11] = mk(1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 1, 0);
    tbl[12] = mk(1, 0, 1, 8'h00, 1, 0, 2, 8'h00, 0, 1);
    tbl[13] = mk(1, 1, 5, 8'h77, 1, 0, 5, 8'h00, 1, 0);  // write wins, read waits
    tbl[14] = mk(0, 0, 0, 8'h00, 1, 0, 5, 8'h00, 0, 1);  // read sees 77
    tbl[15] = mk(1, 0, 4, 8'h00, 0, 0, 0, 8'h00, 1, 0);  // read @4 ...
    tbl[16] = mk(0, 0, 0, 8'h00, 1, 1, 4, 8'h99, 0, 1);  // ... then write @4: read gets old
    tbl[17] = mk(1, 0, 4, 8'h00, 0, 0, 0, 8'h00, 1, 0);  // new value 99

    // Reset held 3 cycles with both requesting.
    rst = 1'b1;
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk_gnt("rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < int'(NT); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk_gnt($sformatf("tbl%0d", i), tbl[i]);
      @(posedge clk);
      #1;
    end
    idle(12);

    // Back-to-back mixed traffic with at least one requester every cycle.
    for (int i = 0; i < 80; i++) begin
      v.r0 = ($urandom_range(3) != 0);
      v.r1 = ($urandom_range(3) != 0);
      if (!v.r0 && !v.r1) v.r0 = 1'b1;
      v.w0 = 1'($urandom_range(1)); v.a0 = 4'($urandom_range(15)); v.d0 = 8'($urandom);
      v.w1 = 1'($urandom_range(1)); v.a1 = 4'($urandom_range(15)); v.d1 = 8'($urandom);
      apply(v);
      @(posedge clk);
      #1;
    end
    idle(12);

    // Reset with two reads in flight; pointer must return to requester 0.
    apply(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 1));
    @(posedge clk); #1;
    apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    apply(mk(1, 0, 3, 0, 1, 0, 4, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_gnt("post_rst", mk(1, 0, 3, 0, 1, 0, 4, 0, 1, 0));
    @(posedge clk); #1;
    idle(14);

    for (int k = 0; k < int'(NI); k++) chk("drained", k, 32'(hd[k]), 32'(sb.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
